// File: rtl/gcd_initiator.sv
// gcd_initiator: sequences one GCD command at a time through an external
// engine, then returns the result (or a timeout abort) downstream.
//
// Ports:
//   clk_i, rst_i                   clock, async active-high reset
//   cmd_valid_i/cmd_ready_o        upstream command handshake
//   cmd_a_i, cmd_b_i               command operands
//   eng_valid_o, eng_a_o, eng_b_o  one-cycle start pulse + operands to engine
//   eng_valid_i, eng_gcd_i         engine result pulse + value
//   rsp_valid_o/rsp_ready_i        downstream response handshake
//   rsp_gcd_o, rsp_err_o           result, timeout-abort flag
//   busy_o                         high whenever not IDLE
//   done_cnt_o                     saturating count of response handshakes
module gcd_initiator #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [WIDTH-1:0] cmd_a_i,
  input  logic [WIDTH-1:0] cmd_b_i,
  output logic             eng_valid_o,
  output logic [WIDTH-1:0] eng_a_o,
  output logic [WIDTH-1:0] eng_b_o,
  input  logic             eng_valid_i,
  input  logic [WIDTH-1:0] eng_gcd_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_gcd_o,
  output logic             rsp_err_o,
  output logic             busy_o,
  output logic [15:0]      done_cnt_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, gcd_q;
  logic             err_q;
  logic [15:0]      tmo_q, done_q;

  logic cmd_hs, zero_op, eng_hit, tmo_hit, rsp_hs;

  assign cmd_hs  = cmd_valid_i && (state_q == IDLE);
  assign zero_op = (cmd_a_i == '0) || (cmd_b_i == '0);
  // A result on the expiry cycle takes priority over the abort.
  assign eng_hit = (state_q == WAIT) && eng_valid_i;
  assign tmo_hit = (state_q == WAIT) && !eng_valid_i && (tmo_q == TMO_LAST);
  assign rsp_hs  = (state_q == RESP) && rsp_ready_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_hs) state_d = zero_op ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (eng_hit || tmo_hit) state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_hs) begin
        a_q <= cmd_a_i;
        b_q <= cmd_b_i;
        // gcd(0,x) = x, so the OR of the operands is the answer directly.
        if (zero_op) begin
          gcd_q <= cmd_a_i | cmd_b_i;
          err_q <= 1'b0;
        end
      end
      if (eng_hit) begin
        gcd_q <= eng_gcd_i;
        err_q <= 1'b0;
      end else if (tmo_hit) begin
        gcd_q <= '0;
        err_q <= 1'b1;
      end
      // Cleared while issuing so it reads 0 on the first WAIT cycle.
      if (state_q == ISSUE)
        tmo_q <= '0;
      else if ((state_q == WAIT) && !eng_valid_i)
        tmo_q <= tmo_q + 16'd1;
      if (rsp_hs && (done_q != 16'hFFFF))
        done_q <= done_q + 16'd1;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign eng_valid_o = (state_q == ISSUE);
  assign eng_a_o     = a_q;
  assign eng_b_o     = b_q;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_gcd_o   = gcd_q;
  assign rsp_err_o   = err_q;
  assign busy_o      = (state_q != IDLE);
  assign done_cnt_o  = done_q;

endmodule

// File: tb/tb_gcd_initiator.sv
// tb_gcd_initiator: table-driven vectors with a response scoreboard, plus
// hand sequences for late engine results and reset during WAIT.
module tb_gcd_initiator;
  localparam int W   = 8;
  localparam int TMO = 16;

  logic         clk_i = 1'b0, rst_i = 1'b1;
  logic         cmd_valid_i = 1'b0, rsp_ready_i = 1'b0, eng_valid_i = 1'b0;
  logic [W-1:0] cmd_a_i = '0, cmd_b_i = '0, eng_gcd_i = '0;
  logic         cmd_ready_o, eng_valid_o, rsp_valid_o, rsp_err_o, busy_o;
  logic [W-1:0] eng_a_o, eng_b_o, rsp_gcd_o;
  logic [15:0]  done_cnt_o;

  gcd_initiator #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i),
    .eng_valid_o(eng_valid_o), .eng_a_o(eng_a_o), .eng_b_o(eng_b_o),
    .eng_valid_i(eng_valid_i), .eng_gcd_i(eng_gcd_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_gcd_o(rsp_gcd_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o), .done_cnt_o(done_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // k: cycle (after handshake) on which the engine answers; 0 = silent.
  typedef struct {
    logic [W-1:0] a, b;
    int           k;
    logic [W-1:0] eg;
    int           hold;
    logic [W-1:0] xg;
    logic         xe;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] g;
    logic         e;
    int           lat;
  } exp_t;

  vec_t tbl[9];
  exp_t sb[$];
  int   npass = 0, ntot = 0, exp_done = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic run(input vec_t v);
    int c, held, neng;
    bit seen, done, stable, rdylow, ab_ok;
    logic [W-1:0] hg;
    logic         he;
    exp_t e;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b1; cmd_a_i = v.a; cmd_b_i = v.b;
    @(negedge clk_i);
    chk("cmd_ready_idle", cmd_ready_o, 1);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    sb.push_back(exp_t'{v.xg, v.xe, v.lat});
    cmd_a_i = ~v.a; cmd_b_i = ~v.b;
    c = 1; held = 0; neng = 0; seen = 0; done = 0; stable = 1; rdylow = 1; ab_ok = 1;
    hg = '0; he = 1'b0;
    while (!done && c <= 60) begin
      eng_valid_i = (c == v.k);
      eng_gcd_i   = (c == v.k) ? v.eg : 8'hEE;
      @(negedge clk_i);
      if (eng_valid_o) begin
        neng++;
        if (eng_a_o !== v.a || eng_b_o !== v.b) ab_ok = 0;
      end
      if (c == 1) chk("busy", busy_o, 1);
      if (rsp_valid_o) begin
        if (!seen) begin
          seen = 1;
          if (sb.size() == 0) chk("sb_empty", 1, 0);
          else begin
            e = sb.pop_front();
            chk("rsp_gcd", rsp_gcd_o, e.g);
            chk("rsp_err", rsp_err_o, e.e);
            chk("rsp_lat", c, e.lat);
          end
          hg = rsp_gcd_o; he = rsp_err_o;
        end else if (rsp_gcd_o !== hg || rsp_err_o !== he) stable = 0;
        if (cmd_ready_o !== 1'b0) rdylow = 0;
        if (held >= v.hold) begin rsp_ready_i = 1'b1; done = 1; end
        else held++;
      end
      @(posedge clk_i); #1;
      c++;
    end
    eng_valid_i = 1'b0; rsp_ready_i = 1'b0;
    if (!done) chk("rsp_timeout", 0, 1);
    else exp_done++;
    chk("eng_pulses", neng, (v.a != 0 && v.b != 0) ? 1 : 0);
    chk("eng_ops", ab_ok, 1);
    chk("rsp_stable", stable, 1);
    chk("rdy_low_in_resp", rdylow, 1);
    @(negedge clk_i);
    chk("cmd_ready_after", cmd_ready_o, 1);
    chk("rsp_valid_after", rsp_valid_o, 0);
    chk("done_cnt", done_cnt_o, exp_done);
  endtask

  initial begin
    bit ok;
    //            a      b      k   eg     hold xg     xe    lat
    tbl[0] = '{8'd12, 8'd18,  5, 8'd6,   0, 8'd6,  1'b0,  6};
    tbl[1] = '{8'd0,  8'd9,   1, 8'h55,  0, 8'd9,  1'b0,  1};
    tbl[2] = '{8'd0,  8'd0,   0, 8'h00,  0, 8'd0,  1'b0,  1};
    tbl[3] = '{8'd3,  8'd5,  17, 8'd1,   0, 8'd1,  1'b0, 18};
    tbl[4] = '{8'd8,  8'd4,   3, 8'd4,  10, 8'd4,  1'b0,  4};
    tbl[5] = '{8'd255,8'd17,  2, 8'd17,  0, 8'd17, 1'b0,  3};
    tbl[6] = '{8'd21, 8'd14, 16, 8'd7,   2, 8'd7,  1'b0, 17};
    tbl[7] = '{8'd9,  8'd0,   0, 8'h00,  1, 8'd9,  1'b0,  1};
    tbl[8] = '{8'd5,  8'd7,   0, 8'h00,  0, 8'd0,  1'b1, 18};

    // Reset state
    @(negedge clk_i);
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_eng_valid", eng_valid_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done_cnt", done_cnt_o, 0);
    chk("rst_rsp_gcd", rsp_gcd_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk("rst_eng_ops", {eng_a_o, eng_b_o}, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    for (int i = 0; i < 9; i++) run(tbl[i]);

    // Late engine result after a timeout abort must be ignored.
    @(posedge clk_i); #1;
    eng_valid_i = 1'b1; eng_gcd_i = 8'h77;
    @(posedge clk_i); #1;
    eng_valid_i = 1'b0;
    @(negedge clk_i);
    chk("late_cmd_ready", cmd_ready_o, 1);
    chk("late_busy", busy_o, 0);
    chk("late_rsp_valid", rsp_valid_o, 0);
    chk("late_rsp_gcd", rsp_gcd_o, 0);
    chk("late_rsp_err", rsp_err_o, 1);
    chk("late_done_cnt", done_cnt_o, exp_done);

    // Reset pulsed during WAIT, engine answers afterwards.
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b1; cmd_a_i = 8'd6; cmd_b_i = 8'd9;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("wait_busy", busy_o, 1);
    chk("wait_cmd_ready", cmd_ready_o, 0);
    #2 rst_i = 1'b1;
    #1 chk("async_rst_ready", cmd_ready_o, 1);
    chk("async_rst_done", done_cnt_o, 0);
    #1 rst_i = 1'b0;
    exp_done = 0;
    @(posedge clk_i); #1;
    eng_valid_i = 1'b1; eng_gcd_i = 8'd3;
    @(posedge clk_i); #1;
    eng_valid_i = 1'b0;
    ok = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || eng_valid_o !== 1'b0 ||
          busy_o !== 1'b0 || done_cnt_o !== 16'd0) ok = 0;
    end
    chk("post_rst_idle", ok, 1);
    chk("post_rst_done_cnt", done_cnt_o, exp_done);
    chk("post_rst_ops", {eng_a_o, eng_b_o}, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/gcd_initiator.md
GCD_INITIATOR -- requirements
Module: gcd_initiator

Interface
REQ-001 Parameter WIDTH, 8, operand and result width in bits.
REQ-002 Parameter TIMEOUT, 1023, maximum WAIT cycles before abort; legal range 1..65535.
REQ-003 Reset rst_i, asynchronous, active-high; clock clk_i.
REQ-004 clk_i  in  1  clock; all state updates on rising edge.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 cmd_valid_i  in  1  upstream command valid.
REQ-007 cmd_ready_o  out  1  initiator accepts a command.
REQ-008 cmd_a_i, cmd_b_i  in  WIDTH each  command operands.
REQ-009 eng_valid_o  out  1  start pulse to the GCD engine.
REQ-010 eng_a_o, eng_b_o  out  WIDTH each  operands to the engine.
REQ-011 eng_valid_i  in  1  engine result-valid pulse.
REQ-012 eng_gcd_i  in  WIDTH  engine result.
REQ-013 rsp_valid_o  out  1  downstream response valid.
REQ-014 rsp_ready_i  in  1  downstream accepts the response.
REQ-015 rsp_gcd_o  out  WIDTH  GCD result.
REQ-016 rsp_err_o  out  1  response is a timeout abort.
REQ-017 busy_o  out  1  high in every state except IDLE.
REQ-018 done_cnt_o  out  16  count of completed response handshakes.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, RESP; an illegal encoding SHALL return to IDLE on the next edge.
REQ-020 cmd_ready_o SHALL be 1 only in IDLE; a handshake is cmd_valid_i and cmd_ready_o high on the same edge.
REQ-021 On a handshake the operands SHALL be captured into internal registers; eng_a_o/eng_b_o SHALL drive those registers and stay stable until the next capture.
REQ-022 IDLE, handshake with both operands nonzero -> ISSUE.
REQ-023 IDLE, handshake with either operand zero -> RESP, without engine issue; rsp_gcd_o = cmd_a_i OR cmd_b_i (gcd(0,x)=x, gcd(0,0)=0); rsp_err_o=0.
REQ-024 ISSUE: eng_valid_o SHALL be 1 for exactly this one cycle, then -> WAIT; eng_valid_o SHALL be 0 in every other state.
REQ-025 On entering WAIT, a timeout counter SHALL be 0; it increments once per WAIT cycle without eng_valid_i.
REQ-026 WAIT, eng_valid_i=1 -> RESP; capture eng_gcd_i into rsp_gcd_o; rsp_err_o=0.
REQ-027 WAIT, counter == TIMEOUT-1 and eng_valid_i=0 -> RESP; rsp_gcd_o=0, rsp_err_o=1.
REQ-028 If eng_valid_i arrives on the same cycle as timeout expiry, the result SHALL win (err=0).
REQ-029 eng_valid_i outside WAIT SHALL be ignored, with no state or output change.
REQ-030 RESP: rsp_valid_o=1; rsp_gcd_o/rsp_err_o SHALL stay stable until rsp_ready_i=1; on that edge -> IDLE.
REQ-031 done_cnt_o SHALL increment on each response handshake and saturate at 16'hFFFF.
REQ-032 Latency, with handshake at cycle 0:
  eng_valid_o at cycle 1.
  Engine result at cycle k -> rsp_valid_o at cycle k+1.
  Zero-operand bypass -> rsp_valid_o at cycle 1.
  Timeout -> rsp_valid_o at cycle 2+TIMEOUT.
REQ-033 Throughput SHALL be one outstanding command at a time; the next cmd_ready_o rises on the cycle after the response handshake.

Reset
REQ-034 rst_i high SHALL force IDLE asynchronously; all outputs 0 except cmd_ready_o=1; the counter, operand registers and done_cnt_o SHALL be cleared.
REQ-035 Reset mid-operation (ISSUE/WAIT/RESP) SHALL discard the pending command; a late eng_valid_i after reset release SHALL be ignored (REQ-029).

Verification
REQ-036 cmd (12,18); engine model returns 6 four cycles after start -> eng_valid_o one cycle with a=12,b=18; rsp_valid_o with gcd=6, err=0; done_cnt_o=1.
REQ-037 cmd (0,9), then (0,0) -> no eng_valid_o; responses gcd=9 then gcd=0, each at cycle 1 after its handshake, err=0.
REQ-038 TIMEOUT=16, engine silent, cmd (5,7) -> rsp_valid_o at cycle 18 with gcd=0, err=1; a later eng_valid_i is ignored.
REQ-039 TIMEOUT=16, eng_valid_i with gcd=1 exactly on the expiry cycle -> gcd=1, err=0.
REQ-040 cmd (8,4), engine returns 4; rsp_ready_i held 0 for 10 cycles -> rsp held stable, cmd_ready_o=0 throughout; handshake -> IDLE next cycle.
REQ-041 rst_i pulsed during WAIT, engine returns 3 afterwards -> rsp_valid_o stays 0, cmd_ready_o=1, done_cnt_o=0.
